// File: rtl/acs_if.sv
// Segment-level bus of the add-compare-select unit: trellis segment inputs and
// the survivor/metric/lowest-state results.
interface acs_if #(
    parameter int WD_DIST  = 2,
    parameter int WD_METR  = 8,
    parameter int WD_FSM   = 6,
    parameter int WD_STATE = 8,
    parameter int N_ACS    = 4
);
    // Active is a valid with no ready: every edge with Active=1 and Hold=0
    // consumes the segment presented, Hold freezes the unit regardless of Active.
    logic                        Active;
    logic                        Init;
    logic                        Hold;
    logic                        CompareStart;
    logic [WD_FSM-1:0]           ACSSegment;
    logic [WD_DIST*2*N_ACS-1:0]  Distance;
    logic [WD_METR*2*N_ACS-1:0]  MMPathMetric;

    logic [N_ACS-1:0]            Survivors;
    logic [WD_STATE-1:0]         LowestState;
    logic [WD_FSM-2:0]           MMReadAddress;
    logic [WD_FSM-1:0]           MMWriteAddress;
    logic                        MMBlockSelect;
    logic [WD_METR*N_ACS-1:0]    MMMetric;

    modport master (
        output Active, Init, Hold, CompareStart, ACSSegment, Distance, MMPathMetric,
        input  Survivors, LowestState, MMReadAddress, MMWriteAddress, MMBlockSelect, MMMetric
    );

    modport slave (
        input  Active, Init, Hold, CompareStart, ACSSegment, Distance, MMPathMetric,
        output Survivors, LowestState, MMReadAddress, MMWriteAddress, MMBlockSelect, MMMetric
    );
endinterface

// File: rtl/acs_unit.sv
// N_ACS parallel add-compare-select cells with a running lowest-state tracker.
// Define ACS_METRIC_SAT_EN to saturate branch sums instead of wrapping them.
module acs_unit #(
    parameter int WD_DIST  = 2,
    parameter int WD_METR  = 8,
    parameter int WD_FSM   = 6,
    parameter int WD_STATE = 8,
    parameter int N_ACS    = 4
) (
    input  logic Clock1,
    input  logic Reset,
    acs_if.slave acs
);
    localparam int WD_IDX = $clog2(N_ACS);

    logic [WD_METR-1:0]       new_metric [N_ACS];
    logic [WD_METR*N_ACS-1:0] metric_flat;
    logic [N_ACS-1:0]         sel_b;

    logic [WD_METR-1:0]       seg_min;
    logic [WD_IDX-1:0]        seg_idx;

    logic                     update;
    logic                     tracker_load;

    logic [N_ACS-1:0]         survivors_q;
    logic [WD_METR*N_ACS-1:0] metric_q;
    logic [WD_FSM-1:0]        waddr_q;
    logic [WD_STATE-1:0]      lowest_state_q;
    logic [WD_METR-1:0]       lowest_metric_q;

    genvar i;
    generate
        for (i = 0; i < N_ACS; i++) begin : g_cell
            logic [WD_METR-1:0] pa, pb, da, db, a, b;

            assign pa = acs.MMPathMetric[(2*i)*WD_METR +: WD_METR];
            assign pb = acs.MMPathMetric[(2*i+1)*WD_METR +: WD_METR];
            assign da = WD_METR'(acs.Distance[(2*i)*WD_DIST +: WD_DIST]);
            assign db = WD_METR'(acs.Distance[(2*i+1)*WD_DIST +: WD_DIST]);

`ifdef ACS_METRIC_SAT_EN
            logic [WD_METR:0] sa, sb;
            assign sa = {1'b0, pa} + {1'b0, da};
            assign sb = {1'b0, pb} + {1'b0, db};
            assign a  = sa[WD_METR] ? '1 : sa[WD_METR-1:0];
            assign b  = sb[WD_METR] ? '1 : sb[WD_METR-1:0];
`else
            assign a = pa + da;
            assign b = pb + db;
`endif

            // Strict compare: a tie keeps the upper branch A.
            assign sel_b[i]      = (b < a);
            assign new_metric[i] = sel_b[i] ? b : a;
            assign metric_flat[i*WD_METR +: WD_METR] = new_metric[i];
        end
    endgenerate

    // Strict less-than scan so the lowest cell index wins ties.
    always_comb begin
        seg_min = new_metric[0];
        seg_idx = '0;
        for (int k = 1; k < N_ACS; k++) begin
            if (new_metric[k] < seg_min) begin
                seg_min = new_metric[k];
                seg_idx = WD_IDX'(k);
            end
        end
    end

    assign update       = acs.Active & ~acs.Hold;
    assign tracker_load = update & (acs.Init | (acs.CompareStart & (seg_min < lowest_metric_q)));

    always_ff @(posedge Clock1 or negedge Reset) begin
        if (!Reset) begin
            survivors_q <= '0;
            metric_q    <= '0;
            waddr_q     <= '0;
        end else if (update) begin
            survivors_q <= sel_b;
            metric_q    <= metric_flat;
            waddr_q     <= acs.ACSSegment;
        end
    end

    // Stored metric resets to all-ones so the first compared segment always wins.
    always_ff @(posedge Clock1 or negedge Reset) begin
        if (!Reset) begin
            lowest_metric_q <= '1;
            lowest_state_q  <= '0;
        end else if (tracker_load) begin
            lowest_metric_q <= seg_min;
            lowest_state_q  <= {acs.ACSSegment, seg_idx};
        end
    end

    assign acs.Survivors      = survivors_q;
    assign acs.MMMetric       = metric_q;
    assign acs.MMWriteAddress = waddr_q;
    assign acs.LowestState    = lowest_state_q;
    assign acs.MMReadAddress  = acs.ACSSegment[WD_FSM-2:0];
    assign acs.MMBlockSelect  = acs.ACSSegment[WD_FSM-1];
endmodule

// File: tb/tb_acs_unit.sv
// Bench for acs_unit: directed segment cases followed by random segments, each
// edge compared against an arithmetic reference model through an expected queue.
module tb_acs_unit;
    localparam int WD_DIST  = 2;
    localparam int WD_METR  = 8;
    localparam int WD_FSM   = 6;
    localparam int WD_STATE = 8;
    localparam int N_ACS    = 4;
    localparam int MAXM     = (1 << WD_METR) - 1;
    localparam int OUT_W    = N_ACS + WD_METR*N_ACS + WD_FSM + WD_STATE;

    logic clk;
    logic rst_n;

    int checks = 0;
    int errors = 0;

    acs_if #(.WD_DIST(WD_DIST), .WD_METR(WD_METR), .WD_FSM(WD_FSM),
             .WD_STATE(WD_STATE), .N_ACS(N_ACS)) bus ();

    acs_unit #(.WD_DIST(WD_DIST), .WD_METR(WD_METR), .WD_FSM(WD_FSM),
               .WD_STATE(WD_STATE), .N_ACS(N_ACS)) dut (
        .Clock1 (clk),
        .Reset  (rst_n),
        .acs    (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int                   m_metric [N_ACS];
    logic [N_ACS-1:0]     m_surv;
    logic [WD_FSM-1:0]    m_waddr;
    int                   m_low_metric;
    logic [WD_STATE-1:0]  m_low_state;
    logic [OUT_W-1:0]     exp_q [$];

    int dv [2*N_ACS];
    int pv [2*N_ACS];

    function automatic void model_reset();
        for (int c = 0; c < N_ACS; c++) m_metric[c] = 0;
        m_surv       = '0;
        m_waddr      = '0;
        m_low_metric = MAXM;
        m_low_state  = '0;
    endfunction

    function automatic int branch_sum(input int p, input int d);
        int s;
        s = p + d;
`ifdef ACS_METRIC_SAT_EN
        if (s > MAXM) s = MAXM;
`else
        s = s % (MAXM + 1);
`endif
        return s;
    endfunction

    function automatic void model_edge();
        int a, b, best;
        logic [WD_METR*N_ACS-1:0] mm;
        if (bus.Active && !bus.Hold) begin
            for (int c = 0; c < N_ACS; c++) begin
                a = branch_sum(int'(bus.MMPathMetric[(2*c)*WD_METR +: WD_METR]),
                               int'(bus.Distance[(2*c)*WD_DIST +: WD_DIST]));
                b = branch_sum(int'(bus.MMPathMetric[(2*c+1)*WD_METR +: WD_METR]),
                               int'(bus.Distance[(2*c+1)*WD_DIST +: WD_DIST]));
                m_surv[c]   = (b < a);
                m_metric[c] = (b < a) ? b : a;
            end
            best = 0;
            for (int c = 1; c < N_ACS; c++)
                if (m_metric[c] < m_metric[best]) best = c;
            if (bus.Init || (bus.CompareStart && m_metric[best] < m_low_metric)) begin
                m_low_metric = m_metric[best];
                m_low_state  = WD_STATE'(int'(bus.ACSSegment) * N_ACS + best);
            end
            m_waddr = bus.ACSSegment;
        end
        for (int c = 0; c < N_ACS; c++) mm[c*WD_METR +: WD_METR] = WD_METR'(m_metric[c]);
        exp_q.push_back({m_surv, mm, m_waddr, m_low_state});
    endfunction

    // ---------------- scoreboard ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_comb(input string tag);
        int seg;
        seg = int'(bus.ACSSegment);
        check({tag, "_raddr"}, 64'(bus.MMReadAddress), 64'(seg % (1 << (WD_FSM-1))));
        check({tag, "_bsel"},  64'(bus.MMBlockSelect), 64'(seg / (1 << (WD_FSM-1))));
    endtask

    task automatic compare_outputs(input string tag);
        logic [OUT_W-1:0]         e;
        logic [N_ACS-1:0]         e_surv;
        logic [WD_METR*N_ACS-1:0] e_mm;
        logic [WD_FSM-1:0]        e_waddr;
        logic [WD_STATE-1:0]      e_ls;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s_queue observed=empty expected=entry", tag);
        end else begin
            e = exp_q.pop_front();
            {e_surv, e_mm, e_waddr, e_ls} = e;
            check({tag, "_surv"},   64'(bus.Survivors),      64'(e_surv));
            check({tag, "_metric"}, 64'(bus.MMMetric),       64'(e_mm));
            check({tag, "_waddr"},  64'(bus.MMWriteAddress), 64'(e_waddr));
            check({tag, "_lowest"}, 64'(bus.LowestState),    64'(e_ls));
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_ctrl(input logic act, input logic init, input logic hold,
                            input logic cs, input logic [WD_FSM-1:0] seg);
        bus.Active       = act;
        bus.Init         = init;
        bus.Hold         = hold;
        bus.CompareStart = cs;
        bus.ACSSegment   = seg;
    endtask

    task automatic apply_data();
        for (int k = 0; k < 2*N_ACS; k++) begin
            bus.Distance[k*WD_DIST +: WD_DIST]     = WD_DIST'(dv[k]);
            bus.MMPathMetric[k*WD_METR +: WD_METR] = WD_METR'(pv[k]);
        end
    endtask

    task automatic random_data();
        for (int k = 0; k < 2*N_ACS; k++) begin
            dv[k] = int'($urandom_range(0, (1 << WD_DIST) - 1));
            pv[k] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(MAXM - 4, MAXM))
                                                : int'($urandom_range(0, MAXM));
        end
        apply_data();
    endtask

    task automatic random_ctrl();
        set_ctrl($urandom_range(0, 7) != 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 7) == 0, 1'($urandom_range(0, 1)),
                 WD_FSM'($urandom_range(0, (1 << WD_FSM) - 1)));
    endtask

    task automatic tick(input string tag);
        model_edge();
        @(posedge clk);
        @(negedge clk);
        compare_outputs(tag);
        check_comb(tag);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_surv"},   64'(bus.Survivors),      64'd0);
        check({tag, "_metric"}, 64'(bus.MMMetric),       64'd0);
        check({tag, "_waddr"},  64'(bus.MMWriteAddress), 64'd0);
        check({tag, "_lowest"}, 64'(bus.LowestState),    64'd0);
        check_comb(tag);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        rst_n = 1'b0;
        random_ctrl();
        random_data();
        model_reset();

        // Reset held with random inputs across edges.
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            random_ctrl();
            random_data();
            #1;
            check_reset_outputs("reset");
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Reference segment: two cells pick B, minimum metric 2 in cell 1.
        set_ctrl(1'b1, 1'b1, 1'b0, 1'b0, 6'd0);
        dv = '{1, 2, 1, 3, 1, 3, 2, 3};
        pv = '{10, 15, 1, 20, 30, 25, 40, 35};
        apply_data();
        tick("ref");
        check("ref_surv_const",   64'(bus.Survivors),   64'b1100);
        check("ref_metric_const", 64'(bus.MMMetric),    64'h26_1C_02_0B);
        check("ref_lowest_const", 64'(bus.LowestState), 64'h01);

        // Compare-mode segment 5 whose cell 3 beats the stored minimum.
        set_ctrl(1'b1, 1'b0, 1'b0, 1'b1, 6'd5);
        dv = '{1, 1, 1, 1, 1, 1, 0, 0};
        pv = '{50, 50, 50, 50, 50, 50, 0, 0};
        apply_data();
        tick("cmp");
        check("cmp_lowest_const", 64'(bus.LowestState),    64'h17);
        check("cmp_waddr_const",  64'(bus.MMWriteAddress), 64'd5);
        check("cmp_bsel_const",   64'(bus.MMBlockSelect),  64'd0);
        check("cmp_raddr_const",  64'(bus.MMReadAddress),  64'd5);

        // Equal branch sums must keep A.
        set_ctrl(1'b1, 1'b0, 1'b0, 1'b0, 6'd33);
        dv = '{2, 3, 0, 0, 0, 0, 0, 0};
        pv = '{5, 4, 100, 100, 100, 100, 100, 100};
        apply_data();
        tick("tie");
        check("tie_surv0",   64'(bus.Survivors[0]),  64'd0);
        check("tie_metric0", 64'(bus.MMMetric[7:0]), 64'd7);

        // Branch sum overflow on A.
        set_ctrl(1'b1, 1'b0, 1'b0, 1'b1, 6'd40);
        dv = '{3, 3, 0, 0, 0, 0, 0, 0};
        pv = '{254, 250, 100, 100, 100, 100, 100, 100};
        apply_data();
        tick("ovf");
`ifdef ACS_METRIC_SAT_EN
        check("ovf_surv0",   64'(bus.Survivors[0]),  64'd1);
        check("ovf_metric0", 64'(bus.MMMetric[7:0]), 64'd253);
`else
        check("ovf_surv0",   64'(bus.Survivors[0]),  64'd0);
        check("ovf_metric0", 64'(bus.MMMetric[7:0]), 64'd1);
`endif

        // Hold overrides Active and Init; then Active low: registers frozen.
        for (int n = 0; n < 3; n++) begin
            random_data();
            set_ctrl(1'b1, 1'b1, 1'b1, 1'b1, WD_FSM'($urandom_range(0, 63)));
            tick("hold");
        end
        for (int n = 0; n < 3; n++) begin
            random_data();
            set_ctrl(1'b0, 1'b1, 1'b0, 1'b1, WD_FSM'($urandom_range(0, 63)));
            tick("idle");
        end

        // Random segments.
        for (int n = 0; n < 150; n++) begin
            random_ctrl();
            random_data();
            tick("rnd");
        end

        // Reset asserted between edges clears outputs immediately.
        set_ctrl(1'b1, 1'b1, 1'b0, 1'b1, 6'd9);
        random_data();
        tick("pre_rst");
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // After reset the stored minimum is all-ones, so compare mode loads.
        for (int n = 0; n < 60; n++) begin
            random_ctrl();
            random_data();
            tick("post");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/acs_unit.md
ACS_UNIT -- requirements
Module: acs_unit

Interface
- REQ-001: Parameter WD_DIST, default 2, is the width of one branch distance.
- REQ-002: Parameter WD_METR, default 8, is the width of one path metric.
- REQ-003: Parameter WD_FSM, default 6, is the width of the segment index.
- REQ-004: Parameter WD_STATE, default 8, is the trellis state index width and SHALL equal WD_FSM+log2(N_ACS).
- REQ-005: Parameter N_ACS, default 4, is the number of parallel ACS cells, a power of 2.
- REQ-006: Clock1, input, 1 bit: the single clock; all state SHALL update on its rising edge.
- REQ-007: Reset, input, 1 bit: asynchronous, active-low reset.
- REQ-008: Active, input, 1 bit: segment data valid.
- REQ-009: Init, input, 1 bit: first segment of a codeword step; restarts lowest-state search.
- REQ-010: Hold, input, 1 bit: freeze all registers.
- REQ-011: CompareStart, input, 1 bit: enables lowest-state tracking.
- REQ-012: ACSSegment, input, WD_FSM bits: current group of N_ACS target states.
- REQ-013: Distance, input, WD_DIST*2*N_ACS bits: branch distance D[k] occupies slice k, with k=0 in the LSBs.
- REQ-014: MMPathMetric, input, WD_METR*2*N_ACS bits: predecessor metric P[k] occupies slice k, with k=0 in the LSBs.
- REQ-015: Survivors, output, N_ACS bits: bit i is the decision of cell i.
- REQ-016: LowestState, output, WD_STATE bits: index of the state with the lowest metric.
- REQ-017: MMReadAddress, output, WD_FSM-1 bits: metric-memory read address.
- REQ-018: MMWriteAddress, output, WD_FSM bits: metric-memory write address.
- REQ-019: MMBlockSelect, output, 1 bit: metric-memory bank select.
- REQ-020: MMMetric, output, WD_METR*N_ACS bits: new metric of cell i occupies slice i.

Function
- REQ-021: An update cycle SHALL be a rising edge with Active=1 and Hold=0; on any other edge all registers SHALL keep their values.
- REQ-022: Cell i SHALL compute A=P[2i]+D[2i] and B=P[2i+1]+D[2i+1], each WD_METR bits wide.
- REQ-023: Cell i SHALL select min(A,B); it SHALL select A on a tie.
- REQ-024: The survivor bit SHALL be 1 if and only if B is selected.
- REQ-025: Survivors, MMMetric and MMWriteAddress (registered copy of ACSSegment) SHALL update on an update cycle, giving a latency of 1 cycle.
- REQ-026: MMReadAddress SHALL be combinational and equal ACSSegment[WD_FSM-2:0].
- REQ-027: MMBlockSelect SHALL be combinational and equal ACSSegment[WD_FSM-1].
- REQ-028: The segment minimum SHALL be the smallest new metric among the cells; on a tie the lowest cell index wins.
- REQ-029: The state index of the segment minimum SHALL be {ACSSegment, i}.
- REQ-030: The tracker SHALL hold a lowest metric and its state index.
- REQ-031: On an update cycle with Init=1, the tracker SHALL load the segment minimum unconditionally, regardless of CompareStart.
- REQ-032: On an update cycle with Init=0 and CompareStart=1, the tracker SHALL load the segment minimum only if it is strictly less than the stored metric.
- REQ-033: On an update cycle with Init=0 and CompareStart=0, the tracker SHALL hold.
- REQ-034: LowestState SHALL be the registered tracker index and SHALL include the segment of the same edge.
- REQ-035: Hold=1 SHALL override Active, Init and CompareStart.

Reset
- REQ-036: While Reset=0, Survivors, MMMetric, MMWriteAddress and LowestState SHALL be 0 and the stored lowest metric SHALL be all-ones.
- REQ-037: Assertion of Reset mid-segment SHALL discard that segment immediately, without waiting for a clock edge.

Configuration
- REQ-038: With ACS_METRIC_SAT_EN defined, each sum A or B SHALL saturate at 2^WD_METR-1.
- REQ-039: Without ACS_METRIC_SAT_EN, each sum A or B SHALL wrap modulo 2^WD_METR.

Verification
- REQ-040: Reset=0 with random inputs -> all outputs 0 except the combinational addresses.
- REQ-041: D={3,2,3,1,3,1,2,1} (k7..k0), P={35,40,25,30,20,1,15,10} (k7..k0), ACSSegment=0, Active=1, Init=1, one edge -> Survivors=4'b1100, MMMetric cells 0..3 = 11, 2, 28, 38, LowestState=0x01.
- REQ-042: After REQ-041, with Init=0, CompareStart=1, ACSSegment=5 and cell 3 new metric 0, the others greater -> LowestState=0x17, MMWriteAddress=5, MMBlockSelect=0, MMReadAddress=5.
- REQ-043: Tie P0+D0=P1+D1=7 -> Survivors[0]=0 and MMMetric cell 0 = 7.
- REQ-044: P0=254, D0=3, P1=250, D1=3 -> with macro: metric 253, Survivors[0]=1; without macro: metric 1, Survivors[0]=0.
- REQ-045: Hold=1 or Active=0 with new inputs for 3 edges -> all registered outputs unchanged.
